// File: rtl/cal_pkg.sv
// Shared definitions for the cal datapath: cs phase encodings and default widths.
package cal_pkg;

    localparam int CW_DEF = 8;

    typedef enum logic [2:0] {
        CS_IDLE = 3'd0,
        CS_PRE  = 3'd1,
        CS_ACC  = 3'd2,
        CS_POST = 3'd3,
        CS_DONE = 3'd4
    } cs_t;

endpackage

// File: rtl/seq_cnt.sv
// In-phase cycle counter; term flags the final cycle of the current phase.
module seq_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] last_val,
    output logic [CW-1:0] count,
    output logic          term
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign count = count_reg;
    assign term  = (count_reg == last_val);

endmodule

// File: rtl/cal_seq.sv
// Start-triggered PRE/ACC/POST phase sequencer with hold, abort and a one-cycle done pulse.
module cal_seq
    import cal_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          hold,
    input  logic          abort,
    input  logic [CW-1:0] pre_len,
    input  logic [CW-1:0] acc_len,
    input  logic [CW-1:0] post_len,
    output logic [2:0]    cs,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done
);

    cs_t           state_reg;
    logic [CW-1:0] pre_len_reg;
    logic [CW-1:0] acc_len_reg;
    logic [CW-1:0] post_len_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [CW-1:0] cur_len;
    logic [CW-1:0] last_val;
    logic          term;
    logic          in_phase;
    logic          phase_end;
    logic          cnt_clr;
    logic          cnt_en;
    cs_t           nxt_from_idle;
    cs_t           nxt_from_phase;

    // First nonzero-length phase strictly after 'from'; DONE when none remain.
    function automatic cs_t next_phase(cs_t from, logic [CW-1:0] p, logic [CW-1:0] a,
                                       logic [CW-1:0] q);
        cs_t n;
        if (from == CS_IDLE && p != '0) begin
            n = CS_PRE;
        end else if ((from == CS_IDLE || from == CS_PRE) && a != '0) begin
            n = CS_ACC;
        end else if (from != CS_POST && q != '0) begin
            n = CS_POST;
        end else begin
            n = CS_DONE;
        end
        return n;
    endfunction

    always_comb begin
        cur_len = '0;
        case (state_reg)
            CS_PRE:  cur_len = pre_len_reg;
            CS_ACC:  cur_len = acc_len_reg;
            CS_POST: cur_len = post_len_reg;
            default: cur_len = '0;
        endcase
    end

    assign last_val       = cur_len - CW'(1);
    assign in_phase       = (state_reg == CS_PRE) || (state_reg == CS_ACC) || (state_reg == CS_POST);
    assign phase_end      = in_phase && !hold && term;
    assign cnt_clr        = abort || !in_phase || phase_end;
    assign cnt_en         = in_phase && !hold;
    assign nxt_from_idle  = next_phase(CS_IDLE, pre_len, acc_len, post_len);
    assign nxt_from_phase = next_phase(state_reg, pre_len_reg, acc_len_reg, post_len_reg);

    seq_cnt #(.CW(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .last_val (last_val),
        .count    (count),
        .term     (term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= CS_IDLE;
            pre_len_reg  <= '0;
            acc_len_reg  <= '0;
            post_len_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                // Abort also suppresses a start arriving in IDLE on the same cycle.
                state_reg <= CS_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    CS_IDLE: begin
                        if (start) begin
                            pre_len_reg  <= pre_len;
                            acc_len_reg  <= acc_len;
                            post_len_reg <= post_len;
                            state_reg    <= nxt_from_idle;
                            busy_reg     <= 1'b1;
                            done_reg     <= (nxt_from_idle == CS_DONE);
                        end
                    end
                    CS_PRE, CS_ACC, CS_POST: begin
                        if (phase_end) begin
                            state_reg <= nxt_from_phase;
                            done_reg  <= (nxt_from_phase == CS_DONE);
                        end
                    end
                    default: begin
                        state_reg <= CS_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cs   = state_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_cal_seq.sv
// Directed bench for cal_seq: phase sequences, skips, hold, abort, restart and reset.
module tb_cal_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pre_len = 8'd0;
    logic [7:0] acc_len = 8'd0;
    logic [7:0] post_len = 8'd0;
    logic [2:0] cs;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    cal_seq #(.CW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hold     (hold),
        .abort    (abort),
        .pre_len  (pre_len),
        .acc_len  (acc_len),
        .post_len (post_len),
        .cs       (cs),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        tests_run++;
        if ({cs, count, busy, done} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_init: cs=%0d count=%0d busy=%b done=%b, expected all 0",
                     cs, count, busy, done);
        end
        pre_len = 8'd1; acc_len = 8'd1; post_len = 8'd1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({cs, count, busy, done} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_held: cs=%0d count=%0d busy=%b done=%b, expected all 0",
                     cs, count, busy, done);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset: outputs held at 0");
    endtask

    task automatic test_basic();
        int ecs [0:10] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 0};
        int ecnt[0:10] = '{0, 1, 2, 0, 1, 0, 1, 2, 3, 0, 0};
        pre_len = 8'd3; acc_len = 8'd2; post_len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tests_run++;
            if (cs !== 3'(ecs[i]) || count !== 8'(ecnt[i]) ||
                busy !== (ecs[i] != 0) || done !== (ecs[i] == 4)) begin
                tests_failed++;
                $display("FAIL basic[%0d]: cs=%0d count=%0d busy=%b done=%b, expected cs=%0d count=%0d busy=%b done=%b",
                         i, cs, count, busy, done, ecs[i], ecnt[i], ecs[i] != 0, ecs[i] == 4);
            end
            @(negedge clk);
        end
        $display("[TB] basic 3/2/4 operation checked");
    endtask

    task automatic test_skip();
        int ecs [0:6] = '{2, 2, 2, 2, 2, 4, 0};
        int ecnt[0:6] = '{0, 1, 2, 3, 4, 0, 0};
        pre_len = 8'd0; acc_len = 8'd5; post_len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            tests_run++;
            if (cs !== 3'(ecs[i]) || count !== 8'(ecnt[i]) ||
                busy !== (ecs[i] != 0) || done !== (ecs[i] == 4)) begin
                tests_failed++;
                $display("FAIL skip_0_5_0[%0d]: cs=%0d count=%0d busy=%b done=%b, expected cs=%0d count=%0d",
                         i, cs, count, busy, done, ecs[i], ecnt[i]);
            end
            @(negedge clk);
        end
        $display("[TB] skip 0/5/0 operation checked");
        pre_len = 8'd0; acc_len = 8'd0; post_len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (cs !== 3'd4 || count !== 8'd0 || busy !== 1'b1 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL skip_0_0_0_done: cs=%0d count=%0d busy=%b done=%b, expected cs=4 count=0 busy=1 done=1",
                     cs, count, busy, done);
        end
        @(negedge clk);
        tests_run++;
        if (cs !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL skip_0_0_0_idle: cs=%0d busy=%b done=%b, expected cs=0 busy=0 done=0",
                     cs, busy, done);
        end
        @(negedge clk);
        $display("[TB] skip 0/0/0 operation checked");
    endtask

    task automatic test_hold();
        int ecs [0:16] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 4, 0};
        int ecnt[0:16] = '{0, 1, 2, 3, 0, 1, 1, 1, 1, 2, 3, 0, 1, 2, 3, 0, 0};
        pre_len = 8'd4; acc_len = 8'd4; post_len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            tests_run++;
            if (cs !== 3'(ecs[i]) || count !== 8'(ecnt[i]) ||
                busy !== (ecs[i] != 0) || done !== (ecs[i] == 4)) begin
                tests_failed++;
                $display("FAIL hold[%0d]: cs=%0d count=%0d busy=%b done=%b, expected cs=%0d count=%0d",
                         i, cs, count, busy, done, ecs[i], ecnt[i]);
            end
            if (i == 5) hold = 1'b1;
            if (i == 8) hold = 1'b0;
            @(negedge clk);
        end
        $display("[TB] hold 4/4/4 operation checked");
    endtask

    task automatic test_abort();
        int ecs [0:8] = '{1, 1, 2, 2, 3, 3, 3, 0, 1};
        int ecnt[0:8] = '{0, 1, 0, 1, 0, 1, 2, 0, 0};
        pre_len = 8'd2; acc_len = 8'd2; post_len = 8'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            tests_run++;
            if (cs !== 3'(ecs[i]) || count !== 8'(ecnt[i]) ||
                busy !== (ecs[i] != 0) || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort[%0d]: cs=%0d count=%0d busy=%b done=%b, expected cs=%0d count=%0d done=0",
                         i, cs, count, busy, done, ecs[i], ecnt[i]);
            end
            if (i == 6) abort = 1'b1;
            if (i == 7) begin
                abort = 1'b0;
                start = 1'b1;
            end
            if (i == 8) start = 1'b0;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (cs !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_cleanup: cs=%0d busy=%b done=%b, expected cs=0 busy=0 done=0",
                     cs, busy, done);
        end
        @(negedge clk);
        $display("[TB] abort 2/2/6 operation checked");
    endtask

    task automatic test_back_to_back();
        int ecs [0:20] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 2, 2, 2, 2, 2, 2, 3, 4, 0};
        int ecnt[0:20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 0, 0, 0};
        pre_len = 8'd1; acc_len = 8'd1; post_len = 8'd1; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 20; i++) begin
            tests_run++;
            if (cs !== 3'(ecs[i]) || count !== 8'(ecnt[i]) ||
                busy !== (ecs[i] != 0) || done !== (ecs[i] == 4)) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: cs=%0d count=%0d busy=%b done=%b, expected cs=%0d count=%0d",
                         i, cs, count, busy, done, ecs[i], ecnt[i]);
            end
            if (i == 6) acc_len = 8'd7;
            if (i == 19) start = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (cs !== 3'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back_stop: cs=%0d busy=%b, expected cs=0 busy=0", cs, busy);
        end
        acc_len = 8'd1;
        @(negedge clk);
        $display("[TB] back-to-back starts checked");
    endtask

    task automatic test_async_reset();
        int ecs [0:3] = '{1, 2, 2, 2};
        int ecnt[0:3] = '{0, 0, 1, 2};
        pre_len = 8'd1; acc_len = 8'd5; post_len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            tests_run++;
            if (cs !== 3'(ecs[i]) || count !== 8'(ecnt[i]) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL async_pre[%0d]: cs=%0d count=%0d busy=%b, expected cs=%0d count=%0d busy=1",
                         i, cs, count, busy, ecs[i], ecnt[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({cs, count, busy, done} !== 13'd0) begin
            tests_failed++;
            $display("FAIL async_reset: cs=%0d count=%0d busy=%b done=%b, expected all 0 before edge",
                     cs, count, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cs, count, busy, done} !== 13'd0) begin
            tests_failed++;
            $display("FAIL async_after: cs=%0d count=%0d busy=%b done=%b, expected all 0",
                     cs, count, busy, done);
        end
        $display("[TB] asynchronous reset mid-ACC checked");
    endtask

    task automatic test_max_len();
        int ecs_i;
        int ecnt_i;
        pre_len = 8'd255; acc_len = 8'd0; post_len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 257; i++) begin
            ecs_i  = (i < 255) ? 1 : (i == 255) ? 3 : (i == 256) ? 4 : 0;
            ecnt_i = (i < 255) ? i : 0;
            tests_run++;
            if (cs !== 3'(ecs_i) || count !== 8'(ecnt_i) ||
                busy !== (ecs_i != 0) || done !== (ecs_i == 4)) begin
                tests_failed++;
                $display("FAIL max_len[%0d]: cs=%0d count=%0d busy=%b done=%b, expected cs=%0d count=%0d",
                         i, cs, count, busy, done, ecs_i, ecnt_i);
            end
            @(negedge clk);
        end
        $display("[TB] PRE length 255 operation checked");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_hold();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cal_seq.md
# cal_seq

Phase sequencer for the `cal` datapath: on a `start` request it drives the `cs` phase code and the in-phase `count` through three programmable-length phases (PRE, ACC, POST), then reports completion. It replaces the free-running `state` generator wherever `cal` must run bounded, software-triggered operations. It supports hold (freeze) and abort, and uses a start/busy/done handshake toward the requesting controller.

## Interface
- `CW`, 8, width of `count` and of the phase-length inputs.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request one operation; sampled only in IDLE.
- `hold`  in  1  freeze sequencing while high; ignored in IDLE and DONE.
- `abort`  in  1  terminate the operation; highest priority.
- `pre_len`  in  CW  PRE phase length in cycles; 0 skips the phase.
- `acc_len`  in  CW  ACC phase length in cycles; 0 skips the phase.
- `post_len`  in  CW  POST phase length in cycles; 0 skips the phase.
- `cs`  out  3  phase code to `cal`: IDLE=0, PRE=1, ACC=2, POST=3, DONE=4; codes 5–7 are unused.
- `count`  out  CW  cycle index within the current phase, starting at 0.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reset value of every output is 0: `cs`=IDLE, `count`=0, `busy`=0, `done`=0. The latched lengths also reset to 0.
- IDLE: `count` holds 0. When `start`=1, latch all three lengths and go to the first phase with a nonzero length, in the order PRE → ACC → POST. If all three lengths are 0, go directly to DONE.
- Lengths are latched once at start. Changes on the length inputs mid-operation have no effect.
- Phase of length N: `count` runs 0,1,…,N−1, so the phase lasts exactly N cycles. On the cycle with `count`=N−1, the block moves to the next nonzero phase with `count`=0, or to DONE after the last such phase. With N=2^CW−1 (255), `count` reaches 254 and must never wrap.
- DONE lasts one cycle: `done`=1, `busy`=1, `count`=0. The block then returns to IDLE. A `start` seen during DONE is ignored.
- `start` while busy is ignored. It is not queued.
- hold=1 in PRE/ACC/POST: `cs` and `count` freeze. The phase resumes where it stopped when `hold` drops. Frozen cycles do not count toward the phase length.
- abort=1 in any non-IDLE state: go to IDLE on the next edge with `count`=0, `busy`=0, and no `done` pulse. `abort` overrides both `hold` and the phase-end transition. If `abort` and `start` are both high in IDLE, the block stays in IDLE.
- `busy` is 1 in PRE, ACC, POST and DONE, and 0 in IDLE.
- All outputs are registered. No combinational path exists from any input to any output.

## Timing
- Start latency: `start` is sampled high at edge k. From edge k+1, `cs` shows the first phase with `count`=0 and `busy`=1.
- Total cycles from start to the `done` cycle: pre_len+acc_len+post_len+1, plus any hold cycles. With all lengths 0 this is 1 cycle, so `done` is asserted at edge k+1.
- Abort latency: 1 cycle. `abort` sampled at edge j gives IDLE at edge j+1.
- Back-to-back operations: the earliest accepted re-start is the first IDLE cycle after DONE. The minimum spacing between accepted starts is total+1 cycles.
- Asserting reset mid-operation forces the reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `cal_pkg` holds:
  - the 3-bit `cs` phase encodings (IDLE, PRE, ACC, POST, DONE);
  - the default `CW`.
- Sub-module `seq_cnt` is a CW-bit phase counter with:
  - inputs `clr` (priority) and `en`;
  - input `last_val` (the latched length minus 1);
  - registered output `count` and combinational output `term`, where `term` = `count`==`last_val`.
- The top level holds the phase FSM, the latched lengths, and the next-nonzero-phase selection logic.

## Test plan
- Lengths 3/2/4 and a one-cycle `start` → `cs` 1,1,1,2,2,3,3,3,3,4,0 with `count` 0,1,2,0,1,0,1,2,3,0,0. `done` is high only on the `cs`=4 cycle; `busy` is high for 10 cycles.
- Lengths 0/5/0 → PRE and POST are skipped, giving `cs`=2 for 5 cycles, then DONE. Lengths 0/0/0 → DONE on the cycle right after `start`.
- Lengths 4/4/4, with `hold` high for 3 cycles while `cs`=2 and `count`=1 → `cs`=2 and `count`=1 for those 3 cycles plus the hold-entry cycle. Total time to DONE is 13+3 cycles.
- `abort` at `cs`=3, `count`=2 (lengths 2/2/6) → next cycle `cs`=0, `busy`=0, and `done` never pulses. A `start` in the following cycle begins a fresh PRE.
- `start` held high continuously with lengths 1/1/1 → operations repeat every 5 cycles (`cs` sequence 1,2,3,4,0). Changing `acc_len` to 7 mid-operation affects only the next operation.
- Asserting `reset` asynchronously mid-ACC → all outputs go to 0 before the next edge. PRE length 255 → `count` reaches 254, then `cs` advances without wrapping.
